// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with optional wait states and a two-cycle ERROR response.
//
// Ports:
//   hclk, hresetn   clock, asynchronous active-low reset
//   hsel, haddr,    address-phase request: select, byte address,
//   hwrite, hsize,  direction, transfer size (log2 bytes),
//   hburst, htrans  burst type (unused: the master sequences addresses), transfer type
//   hready          bus-level ready; an address phase is taken only when it is high
//   hwdata          write data, sampled in the completion cycle of a write
//   hreadyout       slave ready (low in wait states and the first error cycle)
//   hresp           0 = OKAY, 1 = ERROR
//   hrdata          read data, non-zero only in a read completion cycle
module ahb_sram_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [1:0]            htrans,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned Bl       = $clog2(NumBytes);
  localparam int unsigned IdxW     = $clog2(MEM_DEPTH);
  localparam int unsigned KeepW    = Bl + IdxW;
  localparam logic [63:0] MemBytes = 64'(MEM_DEPTH) * 64'(NumBytes);
  localparam logic [2:0]  WaitLast = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StErr1, StErr2} state_e;

  state_e            state_q, state_d;
  // An OKAY transfer owns the current data phase (waiting or completing).
  logic              pend_q, pend_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [KeepW-1:0]  addr_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic              load;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Address-phase decode
  logic                  accept;
  logic                  addr_err, size_err, align_err, req_err;
  logic [ADDR_WIDTH-1:0] align_mask;

  assign accept     = hsel & hready & htrans[1];
  assign addr_err   = 64'(haddr) >= MemBytes;
  assign size_err   = hsize > 3'(Bl);
  assign align_mask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);
  assign align_err  = |(haddr & align_mask);
  assign req_err    = addr_err | size_err | align_err;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      // Both states present hreadyout=1, so both can take a new address phase.
      StIdle, StErr2: begin
        state_d = StIdle;
        pend_d  = 1'b0;
        if (accept) begin
          cnt_d = 3'd0;
          if (req_err) begin
            state_d = StErr1;
          end else begin
            pend_d  = 1'b1;
            load    = 1'b1;
            state_d = (WAIT_STATES > 0) ? StWait : StIdle;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q + 3'd1;
        // Leaving WAIT with pend set makes the next IDLE cycle the completion cycle.
        if (cnt_q == WaitLast) begin
          state_d = StIdle;
        end
      end
      StErr1: begin
        state_d = StErr2;
        pend_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      if (load) begin
        addr_q  <= haddr[KeepW-1:0];
        write_q <= hwrite;
        size_q  <= hsize;
      end
    end
  end

  // Data phase
  logic                complete;
  logic                we;
  logic [IdxW-1:0]     idx;
  logic [Bl-1:0]       off;
  logic [NumBytes-1:0] be;

  assign complete = (state_q == StIdle) && pend_q;
  assign we       = complete && write_q;
  assign idx      = addr_q[Bl +: IdxW];
  assign off      = addr_q[Bl-1:0];

  // Lanes off .. off + 2^size - 1 are written (little-endian).
  always_comb begin
    be = '0;
    for (int k = 0; k < int'(NumBytes); k++) begin
      if ((k >= int'(off)) && (k < int'(off) + (1 << size_q))) begin
        be[k] = 1'b1;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge hclk) begin
    if (we) begin
      for (int k = 0; k < int'(NumBytes); k++) begin
        if (be[k]) begin
          mem[idx][8*k +: 8] <= hwdata[8*k +: 8];
        end
      end
    end
  end

  assign hreadyout = (state_q == StIdle) || (state_q == StErr2);
  assign hresp     = (state_q == StErr1) || (state_q == StErr2);
  assign hrdata    = (complete && !write_q) ? mem[idx] : '0;

  logic unused_burst;
  assign unused_burst = ^hburst;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: one slave with no wait states, one with three.
module tb_ahb_sram_slave;

  localparam logic [1:0] Idle   = 2'b00;
  localparam logic [1:0] Busy   = 2'b01;
  localparam logic [1:0] Nonseq = 2'b10;
  localparam logic [1:0] Seq    = 2'b11;

  logic        hclk = 1'b0;
  logic        rst_n0, rst_n3;
  logic        use3;
  logic [31:0] addr, wdata;
  logic        wr;
  logic [2:0]  size;
  logic [1:0]  trans;
  logic        rdy0, resp0, rdy3, resp3;
  logic [31:0] rdata0, rdata3;

  int n_total = 0;
  int n_bad   = 0;
  int n_low;
  logic [31:0] first_rd;

  always #5 hclk = ~hclk;

  ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .hclk      (hclk),
    .hresetn   (rst_n0),
    .hsel      (!use3),
    .haddr     (addr),
    .hwrite    (wr),
    .hsize     (size),
    .hburst    (3'b001),
    .htrans    (trans),
    .hready    (rdy0),
    .hwdata    (wdata),
    .hreadyout (rdy0),
    .hresp     (resp0),
    .hrdata    (rdata0)
  );

  ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)) u_dut3 (
    .hclk      (hclk),
    .hresetn   (rst_n3),
    .hsel      (use3),
    .haddr     (addr),
    .hwrite    (wr),
    .hsize     (size),
    .hburst    (3'b000),
    .htrans    (trans),
    .hready    (rdy3),
    .hwdata    (wdata),
    .hreadyout (rdy3),
    .hresp     (resp3),
    .hrdata    (rdata3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive address phase + current write data, then settle.
  task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic w,
                       input logic [2:0] s, input logic [31:0] d);
    @(negedge hclk);
    trans = t;
    addr  = a;
    wr    = w;
    size  = s;
    wdata = d;
    #1;
  endtask

  // Idle the bus until u_dut3 is ready; n counts cycles with hreadyout low.
  task automatic wait3(input logic [31:0] d, output int n, output logic [31:0] rd0);
    n = 0;
    drive(Idle, 32'h0, 1'b0, 3'd2, d);
    rd0 = rdata3;
    while (rdy3 !== 1'b1 && n < 20) begin
      n++;
      drive(Idle, 32'h0, 1'b0, 3'd2, d);
    end
  endtask

  initial begin
    use3   = 1'b0;
    rst_n0 = 1'b0;
    rst_n3 = 1'b0;
    trans  = Idle;
    addr   = 32'h0;
    wr     = 1'b0;
    size   = 3'd2;
    wdata  = 32'h0;
    repeat (2) @(negedge hclk);
    #1;
    check_eq("rst_rdy0", {31'b0, rdy0}, 32'd1);
    check_eq("rst_resp0", {31'b0, resp0}, 32'd0);
    check_eq("rst_rdata0", rdata0, 32'h0);
    check_eq("rst_rdy3", {31'b0, rdy3}, 32'd1);
    check_eq("rst_resp3", {31'b0, resp3}, 32'd0);
    rst_n0 = 1'b1;
    rst_n3 = 1'b1;

    // Word write then read of 0x10
    drive(Nonseq, 32'h10, 1'b1, 3'd2, 32'h0);
    drive(Nonseq, 32'h10, 1'b0, 3'd2, 32'hDEADBEEF);
    check_eq("wr_rdy", {31'b0, rdy0}, 32'd1);
    check_eq("wr_resp", {31'b0, resp0}, 32'd0);
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h0);
    check_eq("rd_data", rdata0, 32'hDEADBEEF);
    check_eq("rd_rdy", {31'b0, rdy0}, 32'd1);
    check_eq("rd_resp", {31'b0, resp0}, 32'd0);
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h0);
    check_eq("idle_rdata", rdata0, 32'h0);

    // Byte write into lane 1 of a word
    drive(Nonseq, 32'h20, 1'b1, 3'd2, 32'h0);
    drive(Nonseq, 32'h21, 1'b1, 3'd0, 32'h11223344);
    drive(Nonseq, 32'h20, 1'b0, 3'd2, 32'h0000AA00);
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h0);
    check_eq("byte_merge", rdata0, 32'h1122AA44);

    // Misaligned halfword write must leave word 0 untouched
    drive(Nonseq, 32'h00, 1'b1, 3'd2, 32'h0);
    drive(Nonseq, 32'h01, 1'b1, 3'd1, 32'h55667788);
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'hFFFFFFFF);
    check_eq("mis_e1_resp", {31'b0, resp0}, 32'd1);
    check_eq("mis_e1_rdy", {31'b0, rdy0}, 32'd0);
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'hFFFFFFFF);
    check_eq("mis_e2_resp", {31'b0, resp0}, 32'd1);
    check_eq("mis_e2_rdy", {31'b0, rdy0}, 32'd1);
    check_eq("mis_e2_rdata", rdata0, 32'h0);
    drive(Nonseq, 32'h00, 1'b0, 3'd2, 32'hFFFFFFFF);
    check_eq("post_err_resp", {31'b0, resp0}, 32'd0);
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h0);
    check_eq("mis_mem_kept", rdata0, 32'h55667788);

    // Out of range: 0x400 is one past the last byte
    drive(Nonseq, 32'h400, 1'b0, 3'd2, 32'h0);
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h0);
    check_eq("oor_e1_resp", {31'b0, resp0}, 32'd1);
    check_eq("oor_e1_rdy", {31'b0, rdy0}, 32'd0);
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h0);
    check_eq("oor_e2_resp", {31'b0, resp0}, 32'd1);
    check_eq("oor_e2_rdy", {31'b0, rdy0}, 32'd1);

    // Size wider than the bus
    drive(Nonseq, 32'h08, 1'b0, 3'd3, 32'h0);
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h0);
    check_eq("size_err", {31'b0, resp0}, 32'd1);
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h0);
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h0);
    check_eq("size_recover", {31'b0, resp0}, 32'd0);

    // INCR4 write with a BUSY after beat 2, then INCR4 read
    drive(Nonseq, 32'h40, 1'b1, 3'd2, 32'h0);
    drive(Seq, 32'h44, 1'b1, 3'd2, 32'd1);
    drive(Busy, 32'h48, 1'b1, 3'd2, 32'd2);
    drive(Seq, 32'h48, 1'b1, 3'd2, 32'h0);
    check_eq("busy_rdy", {31'b0, rdy0}, 32'd1);
    check_eq("busy_resp", {31'b0, resp0}, 32'd0);
    drive(Seq, 32'h4C, 1'b1, 3'd2, 32'd3);
    drive(Nonseq, 32'h40, 1'b0, 3'd2, 32'd4);
    drive(Seq, 32'h44, 1'b0, 3'd2, 32'h0);
    check_eq("incr_rd0", rdata0, 32'd1);
    drive(Seq, 32'h48, 1'b0, 3'd2, 32'h0);
    check_eq("incr_rd1", rdata0, 32'd2);
    drive(Seq, 32'h4C, 1'b0, 3'd2, 32'h0);
    check_eq("incr_rd2", rdata0, 32'd3);
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h0);
    check_eq("incr_rd3", rdata0, 32'd4);

    // Three wait states
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h0);
    use3 = 1'b1;
    drive(Nonseq, 32'h08, 1'b1, 3'd2, 32'h0);
    wait3(32'hCAFEF00D, n_low, first_rd);
    check_eq("ws_wr_low", n_low, 32'd3);
    drive(Nonseq, 32'h08, 1'b0, 3'd2, 32'h0);
    wait3(32'h0, n_low, first_rd);
    check_eq("ws_rd_low", n_low, 32'd3);
    check_eq("ws_wait_rdata", first_rd, 32'h0);
    check_eq("ws_rd_data", rdata3, 32'hCAFEF00D);
    check_eq("ws_rd_resp", {31'b0, resp3}, 32'd0);

    // Reset during a write wait state
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h0);
    drive(Nonseq, 32'h08, 1'b1, 3'd2, 32'h0);
    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h12345678);
    check_eq("pre_rst_rdy", {31'b0, rdy3}, 32'd0);
    rst_n3 = 1'b0;
    #1;
    check_eq("async_rst_rdy", {31'b0, rdy3}, 32'd1);
    check_eq("async_rst_resp", {31'b0, resp3}, 32'd0);
    check_eq("async_rst_rdata", rdata3, 32'h0);
    repeat (2) @(negedge hclk);
    rst_n3 = 1'b1;
    drive(Nonseq, 32'h08, 1'b0, 3'd2, 32'h0);
    wait3(32'h0, n_low, first_rd);
    check_eq("rst_mem_kept", rdata3, 32'hCAFEF00D);

    drive(Idle, 32'h0, 1'b0, 3'd2, 32'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
